// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one request at a time,
// serviced after LATENCY cycles against an internal 64-bit word array.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic        req_wen_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        addr_q;
    logic [63:0]        wdata_q;
    logic               wen_q;
    logic [1:0]         size_q;
    logic               uns_q;

    logic [63:0]        mem [DEPTH_WORDS];

    logic [63:0]        offset;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic [IDX_W-1:0]   idx;
    logic [5:0]         shamt;
    logic [63:0]        size_mask;
    logic [63:0]        rd_word;
    logic [63:0]        merged;
    logic [63:0]        load_val;
    logic               do_access;

    // Right-align the selected lanes, then sign- or zero-extend by size.
    function automatic logic [63:0] load_extend(input logic [63:0] shifted,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [63:0] ext;
        case (size)
            2'd0:    ext = uns ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ext = uns ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ext = uns ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
        return ext;
    endfunction

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign do_access    = (state == WAIT) && (cnt == '0);

    always_comb begin
        offset       = addr_q - BASE_ADDR;
        out_of_range = (addr_q < BASE_ADDR) || (offset >= SPAN);
        case (size_q)
            2'd1:    misaligned = addr_q[0];
            2'd2:    misaligned = |addr_q[1:0];
            2'd3:    misaligned = |addr_q[2:0];
            default: misaligned = 1'b0;
        endcase
        acc_err = misaligned || out_of_range;
        idx     = offset[IDX_W+2:3];
        shamt   = {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
        rd_word  = mem[idx];
        merged   = (rd_word & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
        load_val = load_extend(rd_word >> shamt, size_q, uns_q);
    end

    // Request fields are only captured on acceptance; they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wen_q   <= req_wen_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && wen_q && !acc_err)
            mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    cnt   <= CNT_W'(LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    resp_err_o   <= acc_err;
                    resp_rdata_o <= (acc_err || wen_q) ? 64'h0 : load_val;
                    state        <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (resp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, error cases,
// response backpressure and reset during an outstanding store.
module tb_dmem_responder;

    localparam int unsigned LATENCY = 2;
    localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic        req_wen_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] sb [$];

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LATENCY),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_wen_i     (req_wen_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_rdata_o  (resp_rdata_o),
        .resp_err_o    (resp_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, push its expected response, then
    // pop and compare when the DUT presents it. Returns on a negedge.
    task automatic xact(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        int guard;
        bit done;
        logic [64:0] e;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_wen_i      = wen;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_valid_i    = 1'b1;
        resp_ready_i   = (hold == 0);
        sb.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat  = 0;
        done = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid_o) done = 1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        e = sb.pop_front();
        if (!done) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            resp_ready_i = 1'b1;
            return;
        end
        check({tag, "_rdata"}, resp_rdata_o, e[63:0]);
        check({tag, "_err"}, 64'(resp_err_o), 64'(e[64]));
        check({tag, "_busy"}, 64'(req_ready_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(resp_valid_o), 64'd1);
            check({tag, "_hold_rdata"}, resp_rdata_o, e[63:0]);
            check({tag, "_hold_err"}, 64'(resp_err_o), 64'(e[64]));
            check({tag, "_hold_ready"}, 64'(req_ready_o), 64'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_post_ready"}, 64'(req_ready_o), 64'd1);
        check({tag, "_post_valid"}, 64'(resp_valid_o), 64'd0);
        check({tag, "_post_rdata"}, resp_rdata_o, e[63:0]);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid_i    = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        req_wen_i      = 1'b0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        resp_ready_i   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_valid", 64'(resp_valid_o), 64'd0);
        check("rst_rdata", resp_rdata_o, 64'd0);
        check("rst_err", 64'(resp_err_o), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(req_ready_o), 64'd1);
            check("idle_valid", 64'(resp_valid_o), 64'd0);
        end

        xact("st_d",   BASE + 64'h10, 64'h1122_3344_5566_8788, 1, 2'd3, 0, 64'h0, 0, 0);
        xact("ld_d",   BASE + 64'h10, 64'h0, 0, 2'd3, 0, 64'h1122_3344_5566_8788, 0, 0);
        xact("st_b",   BASE + 64'h13, 64'hFFFF_FFFF_FFFF_FF9A, 1, 2'd0, 0, 64'h0, 0, 0);
        xact("ld_bs",  BASE + 64'h13, 64'h0, 0, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FF9A, 0, 0);
        xact("ld_bu",  BASE + 64'h13, 64'h0, 0, 2'd0, 1, 64'h0000_0000_0000_009A, 0, 0);
        xact("ld_wu",  BASE + 64'h10, 64'h0, 0, 2'd2, 1, 64'h0000_0000_9A66_8788, 0, 0);
        xact("ld_ws",  BASE + 64'h10, 64'h0, 0, 2'd2, 0, 64'hFFFF_FFFF_9A66_8788, 0, 0);
        xact("ld_hs",  BASE + 64'h12, 64'h0, 0, 2'd1, 0, 64'hFFFF_FFFF_FFFF_9A66, 0, 0);
        xact("ld_wu4", BASE + 64'h14, 64'h0, 0, 2'd2, 1, 64'h0000_0000_1122_3344, 0, 0);

        xact("ld_mis", BASE + 64'h12, 64'h0, 0, 2'd2, 0, 64'h0, 1, 0);
        xact("st_lo",  64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd3, 0, 64'h0, 1, 0);
        xact("st_hi",  BASE + 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd3, 0, 64'h0, 1, 0);
        xact("st_dmis", BASE + 64'h14, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd3, 0, 64'h0, 1, 0);
        xact("ld_keep", BASE + 64'h10, 64'h0, 0, 2'd3, 0, 64'h1122_3344_9A66_8788, 0, 0);

        xact("st_last", BASE + 64'h1FF8, 64'hA5A5_0000_1234_5678, 1, 2'd3, 0, 64'h0, 0, 0);
        xact("ld_last", BASE + 64'h1FF8, 64'h0, 0, 2'd3, 0, 64'hA5A5_0000_1234_5678, 0, 0);

        xact("ld_bp",   BASE + 64'h10, 64'h0, 0, 2'd3, 0, 64'h1122_3344_9A66_8788, 0, 5);

        xact("st_zero", BASE + 64'h20, 64'h0, 1, 2'd3, 0, 64'h0, 0, 0);
        req_addr_i  = BASE + 64'h20;
        req_wdata_i = 64'h0000_0000_DEAD_BEEF;
        req_wen_i   = 1'b1;
        req_size_i  = 2'd3;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("wait_busy", 64'(req_ready_o), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(req_ready_o), 64'd1);
        check("abort_valid", 64'(resp_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_noresp", 64'(resp_valid_o), 64'd0);
        end
        xact("ld_abort", BASE + 64'h20, 64'h0, 0, 2'd3, 0, 64'h0, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
